// File: rtl/hysteresis_pkg.sv
// rtl/hysteresis_pkg.sv - shared image constants and reader state codes for the hysteresis stage
package hysteresis_pkg;

    localparam int IMG_WIDTH  = 1280;
    localparam int IMG_HEIGHT = 720;

    typedef logic [1:0] rd_state_t;

    localparam rd_state_t ST_IDLE   = 2'd0;
    localparam rd_state_t ST_STREAM = 2'd1;
    localparam rd_state_t ST_DRAIN  = 2'd2;
    localparam rd_state_t ST_DONE   = 2'd3;

endpackage

// File: rtl/pixel_skid_buffer.sv
// rtl/pixel_skid_buffer.sv - 2-entry in-order pixel buffer; head is always the oldest entry
module pixel_skid_buffer (
    input  logic       clock,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] head,
    output logic [1:0] count
);

    logic [7:0] mem0;
    logic [7:0] mem1;

    assign head = mem0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem0  <= 8'd0;
            mem1  <= 8'd0;
            count <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) mem0 <= push_data;
                    else               mem1 <= push_data;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    mem0  <= mem1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    // Occupancy unchanged: the new pixel lands behind whatever stays
                    if (count == 2'd1) begin
                        mem0 <= push_data;
                    end else begin
                        mem0 <= mem1;
                        mem1 <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/hysteresis_reader.sv
// rtl/hysteresis_reader.sv - streams the finished hysteresis BRAM frame into the downstream FIFO
module hysteresis_reader
    import hysteresis_pkg::*;
#(
    parameter  int WIDTH      = IMG_WIDTH,
    parameter  int HEIGHT     = IMG_HEIGHT,
    parameter  int IMAGE_SIZE = WIDTH * HEIGHT,
    localparam int AW         = $clog2(IMAGE_SIZE)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    output logic [AW-1:0] bram_rd_addr,
    input  logic [7:0]    bram_rd_data,
    output logic [7:0]    out_din,
    output logic          out_wr_en,
    input  logic          out_full,
    output logic          busy,
    output logic          read_done
);

    localparam logic [AW:0] SIZE_W = (AW+1)'(IMAGE_SIZE);
    localparam logic [AW:0] LAST_W = (AW+1)'(IMAGE_SIZE - 1);

    rd_state_t     state;
    logic [AW:0]   addr_cnt;
    logic [AW-1:0] addr_hold;
    logic          rd_inflight;
    logic [1:0]    buf_count;
    logic [7:0]    buf_head;
    logic          pop;
    logic          rd_issue;
    logic [2:0]    occ_eff;

    assign pop = (buf_count != 2'd0) && !out_full;

    // A head leaving this cycle frees its slot before the issued read returns,
    // which is what sustains one pixel per cycle.
    assign occ_eff  = {1'b0, buf_count} - {2'b00, pop} + {2'b00, rd_inflight};
    assign rd_issue = (state == ST_STREAM) && (addr_cnt < SIZE_W) && (occ_eff < 3'd2);

    assign bram_rd_addr = rd_issue ? addr_cnt[AW-1:0] : addr_hold;
    assign out_wr_en    = pop;
    assign out_din      = buf_head;
    assign busy         = (state != ST_IDLE);
    assign read_done    = (state == ST_DONE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            addr_cnt    <= '0;
            addr_hold   <= '0;
            rd_inflight <= 1'b0;
        end else begin
            rd_inflight <= rd_issue;
            if (rd_issue) begin
                addr_cnt  <= addr_cnt + {{AW{1'b0}}, 1'b1};
                addr_hold <= addr_cnt[AW-1:0];
            end
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_STREAM;
                        addr_cnt <= '0;
                    end
                end
                ST_STREAM: begin
                    if (rd_issue && (addr_cnt == LAST_W)) state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (!rd_inflight && (buf_count == 2'd0)) state <= ST_DONE;
                end
                ST_DONE:  state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    pixel_skid_buffer u_buf (
        .clock     (clock),
        .reset     (reset),
        .push      (rd_inflight),
        .push_data (bram_rd_data),
        .pop       (pop),
        .head      (buf_head),
        .count     (buf_count)
    );

endmodule

// File: tb/tb_hysteresis_reader.sv
// tb/tb_hysteresis_reader.sv - self-checking bench for hysteresis_reader on a 4x3 frame
module tb_hysteresis_reader;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int N  = W * H;
    localparam int AW = $clog2(N);
    localparam int TBL_LEN = 18;

    localparam int M_PLAIN   = 0;
    localparam int M_FULLWIN = 1;
    localparam int M_TOGGLE  = 2;
    localparam int M_SECOND  = 3;
    localparam int M_RESET   = 4;
    localparam int M_B2B     = 5;
    localparam int M_RANDOM  = 6;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          out_full = 1'b0;
    logic [AW-1:0] bram_rd_addr;
    logic [7:0]    bram_rd_data = 8'd0;
    logic [7:0]    out_din;
    logic          out_wr_en;
    logic          busy;
    logic          read_done;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic          start;
        logic          full;
        logic          exp_wr;
        logic [7:0]    exp_din;
        logic          exp_done;
        logic          exp_busy;
        logic [AW-1:0] exp_addr;
    } vec_t;

    vec_t tbl [TBL_LEN];

    hysteresis_reader #(.WIDTH(W), .HEIGHT(H)) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .bram_rd_addr (bram_rd_addr),
        .bram_rd_data (bram_rd_data),
        .out_din      (out_din),
        .out_wr_en    (out_wr_en),
        .out_full     (out_full),
        .busy         (busy),
        .read_done    (read_done)
    );

    always #5 clock = ~clock;

    // BRAM image: one-cycle read latency, content = address + 10
    always @(posedge clock) bram_rd_data <= 8'(bram_rd_addr) + 8'd10;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " rst wr_en"}, 32'(out_wr_en), 32'd0);
        check({tag, " rst done"},  32'(read_done), 32'd0);
        check({tag, " rst busy"},  32'(busy), 32'd0);
        check({tag, " rst addr"},  32'(bram_rd_addr), 32'd0);
        check({tag, " rst din"},   32'(out_din), 32'd0);
    endtask

    task automatic run_scen(input string tag, input int mode, input int ncyc, input int exp_frames);
        int   exp_next = 0;
        int   frames = 0;
        int   dones = 0;
        int   writes_frame = 0;
        int   rd_hi = 0;
        int   starts = 0;
        logic prev_done = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clock);
            #1;
            start = (c == 0) || (mode == M_SECOND && c == 6) || (mode == M_RESET && c == 10) ||
                    (mode == M_B2B && prev_done && starts < 2);
            if (start) starts++;
            case (mode)
                M_FULLWIN: out_full = (c >= 4 && c <= 9);
                M_TOGGLE:  out_full = (c % 2 == 1);
                M_RANDOM:  out_full = ($urandom_range(0, 2) == 0);
                default:   out_full = 1'b0;
            endcase
            if (mode == M_RESET && c == 7) begin
                reset = 1'b0;
                #1;
                check_reset_outputs(tag);
                exp_next = 0;
            end
            if (mode == M_RESET && c == 9) reset = 1'b1;
            @(negedge clock);
            if (mode == M_RESET && c >= 7 && c <= 10)
                check({tag, " wr after reset"}, 32'(out_wr_en), 32'd0);
            if (out_full) check({tag, " wr while full"}, 32'(out_wr_en), 32'd0);
            if (out_wr_en) begin
                check({tag, " data"}, 32'(out_din), 32'(exp_next + 10));
                exp_next++;
                writes_frame++;
                if (exp_next == N) begin
                    exp_next = 0;
                    frames++;
                end
            end
            if (read_done) begin
                dones++;
                check({tag, " done at frame end"}, 32'(exp_next), 32'd0);
            end
            if (mode == M_FULLWIN && busy) begin
                if (int'(bram_rd_addr) + 1 > rd_hi) rd_hi = int'(bram_rd_addr) + 1;
                check({tag, " read-ahead"}, 32'(rd_hi - writes_frame <= 2), 32'd1);
            end
            prev_done = read_done;
        end
        start = 1'b0;
        out_full = 1'b0;
        check({tag, " frames"}, 32'(frames), 32'(exp_frames));
        check({tag, " done count"}, 32'(dones), 32'(exp_frames));
        check({tag, " partial"}, 32'(exp_next), 32'd0);
        check({tag, " idle at end"}, 32'(busy), 32'd0);
    endtask

    initial begin
        for (int c = 0; c < TBL_LEN; c++) begin
            tbl[c].start    = (c == 0);
            tbl[c].full     = 1'b0;
            tbl[c].exp_wr   = (c >= 3 && c <= 14);
            tbl[c].exp_din  = 8'(c + 7);
            tbl[c].exp_done = (c == 16);
            tbl[c].exp_busy = (c >= 1 && c <= 16);
            tbl[c].exp_addr = (c == 0) ? AW'(0) : AW'((c - 1 > N - 1) ? N - 1 : c - 1);
        end

        repeat (3) @(posedge clock);
        @(negedge clock);
        check_reset_outputs("init");
        @(posedge clock);
        #1;
        reset = 1'b1;

        for (int c = 0; c < TBL_LEN; c++) begin
            @(posedge clock);
            #1;
            start = tbl[c].start;
            out_full = tbl[c].full;
            @(negedge clock);
            check($sformatf("tbl c%0d wr_en", c), 32'(out_wr_en), 32'(tbl[c].exp_wr));
            if (tbl[c].exp_wr) check($sformatf("tbl c%0d din", c), 32'(out_din), 32'(tbl[c].exp_din));
            check($sformatf("tbl c%0d done", c), 32'(read_done), 32'(tbl[c].exp_done));
            check($sformatf("tbl c%0d busy", c), 32'(busy), 32'(tbl[c].exp_busy));
            check($sformatf("tbl c%0d addr", c), 32'(bram_rd_addr), 32'(tbl[c].exp_addr));
        end
        start = 1'b0;

        run_scen("plain",   M_PLAIN,   24, 1);
        run_scen("fullwin", M_FULLWIN, 32, 1);
        run_scen("toggle",  M_TOGGLE,  40, 1);
        run_scen("second",  M_SECOND,  24, 1);
        run_scen("reset",   M_RESET,   34, 1);
        run_scen("b2b",     M_B2B,     42, 2);
        for (int r = 0; r < 6; r++) run_scen($sformatf("rand%0d", r), M_RANDOM, 90, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
